wb_register_file: RTL and testbench
===================================

WB_REGISTER_FILE -- requirements
Module: wb_register_file

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous active-high reset.
REQ-004 RegWrite3  input  1  write enable from the MEM/WB stage.
REQ-005 MemtoReg3  input  2  writeback source select: 0 ALU, 1 memory, 2 link (PC+4), 3 reserved.
REQ-006 ReadData_out  input  32  load data from the MEM/WB stage.
REQ-007 ALUResult_out2  input  32  ALU result from the MEM/WB stage.
REQ-008 PCAddResult4  input  32  PC+4 from the MEM/WB stage, used as the link value.
REQ-009 MEMWBRTorRd  input  5  destination register index.
REQ-010 ReadRegister1, ReadRegister2  input  5 each  ID-stage source indices.
REQ-011 ReadData1, ReadData2  output  32 each  ID-stage operand values.
REQ-012 WriteData  output  32  selected writeback value, also used by the forwarding unit.
REQ-013 WriteCount  output  32  count of committed architectural writes, for debug.

Function
REQ-014 Writeback mux SHALL be combinational.
- Sel 0 gives ALUResult_out2; sel 1 gives ReadData_out; sel 2 gives PCAddResult4.
- Sel 3 gives ALUResult_out2.
REQ-015 The register array SHALL be 32 entries by 32 bits.
- A write occurs on the rising Clk edge when RegWrite3=1, MEMWBRTorRd!=0 and Reset=0.
REQ-016 Register 0 SHALL always read 0, and writes to it SHALL be discarded.
- Such a write is not counted.
REQ-017 Read ports SHALL be combinational (zero latency).
REQ-018 Write-through bypass SHALL apply to each read port independently.
- Condition: RegWrite3=1, MEMWBRTorRd!=0, and MEMWBRTorRd equals the read index.
- When the condition holds, the port SHALL return WriteData in the same cycle.
REQ-019 When both read ports address the written register in the same cycle, both SHALL return the bypassed WriteData.
REQ-020 WriteCount SHALL increment by 1 on each committed write.
- It SHALL wrap from 0xFFFFFFFF to 0.
REQ-021 When RegWrite3=0, the array and WriteCount SHALL hold.
- The value of WriteData in this case has no effect on state.
REQ-022 Back-to-back writes to the same index SHALL leave the last written value.
- Each of those writes SHALL count.
REQ-023 All inputs SHALL have X-free outputs whenever the inputs are X-free.
- This includes reserved select 3.

Reset
REQ-024 While Reset=1 at a Clk edge, all 32 registers SHALL clear to 0 and WriteCount SHALL clear to 0.
- Reset has priority over any simultaneous write.
REQ-025 During Reset, read ports SHALL apply no bypass and SHALL read 0.
REQ-026 WriteData SHALL remain combinational from its inputs during reset.
REQ-027 Deasserting Reset mid-program SHALL resume normal writes on the first edge with Reset=0.

Structure
REQ-028 A shared package SHALL hold the following definitions:
- MemtoReg encodings WB_SEL_ALU=0, WB_SEL_MEM=1, WB_SEL_LINK=2.
- Widths DATA_W=32, REG_IDX_W=5, NUM_REGS=32.
REQ-029 The writeback mux SHALL be a separate sub-module, wb_mux, instantiated once.
REQ-030 The array SHALL be inferable as flip-flops.
- The design SHALL NOT depend on vendor RAM primitives.

Verification
REQ-031 Reset then read all 32 indices: every ReadData1 and ReadData2 is 0, and WriteCount=0.
REQ-032 Write with RegWrite3=1, MemtoReg3=0, ALUResult_out2=0x0000_00AB, MEMWBRTorRd=5.
- ReadData1 with ReadRegister1=5 is 0x0000_00AB in the same cycle (bypass).
- After the edge it is 0x0000_00AB from the array, and WriteCount=1.
REQ-033 Write with MemtoReg3=2, PCAddResult4=0x0040_0008, MEMWBRTorRd=31.
- R31 reads 0x0040_0008.
- Repeat with MemtoReg3=1 and ReadData_out=0xDEAD_BEEF: R31 reads 0xDEAD_BEEF.
REQ-034 Write 0xFFFF_FFFF to index 0.
- R0 reads 0 both during and after the cycle, and WriteCount is unchanged.
REQ-035 Assert Reset=1 together with RegWrite3=1, index 7, value 0x1234.
- R7 reads 0 after the edge, and WriteCount=0.
- Next cycle, with Reset=0, the same write gives R7=0x1234.
REQ-036 Force WriteCount to 0xFFFF_FFFF via hierarchical deposit, then commit one write: WriteCount=0.

Source files
------------

// File: rtl/wb_register_file_pkg.sv
// Shared definitions for the MEM/WB writeback path and the architectural register file.
package wb_register_file_pkg;

    // Datapath and register-file geometry
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned NUM_REGS  = 32;

    // Writeback source select encodings (MemtoReg3)
    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_MEM  = 2'd1;
    localparam logic [1:0] WB_SEL_LINK = 2'd2;
    localparam logic [1:0] WB_SEL_RSVD = 2'd3;

    typedef logic [DATA_W-1:0]    data_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // A write reaches the array only when enabled, not aimed at r0 and not under reset.
    function automatic logic write_commits(input logic     reg_write,
                                           input reg_idx_t dst,
                                           input logic     reset);
        return reg_write && (dst != '0) && !reset;
    endfunction

    // Same-cycle bypass for one read port; suppressed during reset so reads stay 0.
    function automatic logic bypass_hit(input logic     reg_write,
                                        input reg_idx_t dst,
                                        input reg_idx_t src,
                                        input logic     reset);
        return write_commits(reg_write, dst, reset) && (dst == src);
    endfunction

endpackage

// File: rtl/wb_mux.sv
// Combinational writeback source selector. The reserved encoding falls back to the
// ALU result so the output is always a defined data value.
module wb_mux
    import wb_register_file_pkg::*;
(
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] link_addr,
    output logic [DATA_W-1:0] wb_data
);

    // Pick the writeback value; every encoding is covered so no latch and no X.
    always_comb begin
        wb_data = alu_result;
        unique case (sel)
            WB_SEL_ALU:  wb_data = alu_result;
            WB_SEL_MEM:  wb_data = mem_data;
            WB_SEL_LINK: wb_data = link_addr;
            WB_SEL_RSVD: wb_data = alu_result;
            default:     wb_data = alu_result;
        endcase
    end

endmodule

// File: rtl/wb_register_file.sv
// 32 x 32 architectural register file with writeback mux, write-through bypass on both
// read ports, hardwired zero register and a committed-write counter for debug.
module wb_register_file
    import wb_register_file_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 RegWrite3,
    input  logic [1:0]           MemtoReg3,
    input  logic [DATA_W-1:0]    ReadData_out,
    input  logic [DATA_W-1:0]    ALUResult_out2,
    input  logic [DATA_W-1:0]    PCAddResult4,
    input  logic [REG_IDX_W-1:0] MEMWBRTorRd,
    input  logic [REG_IDX_W-1:0] ReadRegister1,
    input  logic [REG_IDX_W-1:0] ReadRegister2,
    output logic [DATA_W-1:0]    ReadData1,
    output logic [DATA_W-1:0]    ReadData2,
    output logic [DATA_W-1:0]    WriteData,
    output logic [DATA_W-1:0]    WriteCount
);

    data_t regs_q [NUM_REGS];
    data_t write_count_q;
    data_t write_count_d;
    logic  write_en;
    logic  bypass1;
    logic  bypass2;

    wb_mux u_wb_mux (
        .sel        (MemtoReg3),
        .alu_result (ALUResult_out2),
        .mem_data   (ReadData_out),
        .link_addr  (PCAddResult4),
        .wb_data    (WriteData)
    );

    assign write_en = write_commits(RegWrite3, MEMWBRTorRd, Reset);
    assign bypass1  = bypass_hit(RegWrite3, MEMWBRTorRd, ReadRegister1, Reset);
    assign bypass2  = bypass_hit(RegWrite3, MEMWBRTorRd, ReadRegister2, Reset);

    // Counter next state; natural 32-bit overflow gives the wrap to zero.
    always_comb begin
        write_count_d = write_count_q;
        if (write_en) begin
            write_count_d = write_count_q + 32'd1;
        end
    end

    // Register array: reset clears every entry and beats any simultaneous write.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (write_en) begin
            regs_q[MEMWBRTorRd] <= WriteData;
        end
    end

    // Committed-write counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            write_count_q <= '0;
        end else begin
            write_count_q <= write_count_d;
        end
    end

    // Read ports: r0 and reset force zero, a matching write is forwarded, else the array.
    always_comb begin
        ReadData1 = regs_q[ReadRegister1];
        ReadData2 = regs_q[ReadRegister2];
        if (bypass1) begin
            ReadData1 = WriteData;
        end
        if (bypass2) begin
            ReadData2 = WriteData;
        end
        if (Reset || ReadRegister1 == '0) begin
            ReadData1 = '0;
        end
        if (Reset || ReadRegister2 == '0) begin
            ReadData2 = '0;
        end
    end

    assign WriteCount = write_count_q;

endmodule

// File: tb/tb_wb_register_file.sv
// Self-checking bench for wb_register_file: table of per-cycle vectors with expected
// combinational outputs, fed through an expectation queue, plus hand-written sequences.
module tb_wb_register_file;

    logic        Clk;
    logic        Reset;
    logic        RegWrite3;
    logic [1:0]  MemtoReg3;
    logic [31:0] ReadData_out;
    logic [31:0] ALUResult_out2;
    logic [31:0] PCAddResult4;
    logic [4:0]  MEMWBRTorRd;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [31:0] WriteData;
    logic [31:0] WriteCount;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst;
        logic        we;
        logic [1:0]  sel;
        logic [4:0]  dst;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] link;
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic [31:0] exp_rd1;
        logic [31:0] exp_rd2;
        logic [31:0] exp_wd;
        logic [31:0] exp_cnt;
    } vec_t;

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] wd;
        logic [31:0] cnt;
    } exp_t;

    vec_t vecs [15];
    exp_t sb_q [$];

    wb_register_file dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .RegWrite3      (RegWrite3),
        .MemtoReg3      (MemtoReg3),
        .ReadData_out   (ReadData_out),
        .ALUResult_out2 (ALUResult_out2),
        .PCAddResult4   (PCAddResult4),
        .MEMWBRTorRd    (MEMWBRTorRd),
        .ReadRegister1  (ReadRegister1),
        .ReadRegister2  (ReadRegister2),
        .ReadData1      (ReadData1),
        .ReadData2      (ReadData2),
        .WriteData      (WriteData),
        .WriteCount     (WriteCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one vector just after a rising edge and queue what it should produce.
    task automatic drive(input vec_t v);
        exp_t e;
        @(posedge Clk);
        #1;
        Reset          = v.rst;
        RegWrite3      = v.we;
        MemtoReg3      = v.sel;
        MEMWBRTorRd    = v.dst;
        ALUResult_out2 = v.alu;
        ReadData_out   = v.mem;
        PCAddResult4   = v.link;
        ReadRegister1  = v.rr1;
        ReadRegister2  = v.rr2;
        e.rd1 = v.exp_rd1;
        e.rd2 = v.exp_rd2;
        e.wd  = v.exp_wd;
        e.cnt = v.exp_cnt;
        sb_q.push_back(e);
    endtask

    // Sample on the falling edge and compare against the oldest queued expectation.
    task automatic sample(input string tag);
        exp_t e;
        @(negedge Clk);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: expectation queue empty", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, " ReadData1"}, ReadData1, e.rd1);
            check({tag, " ReadData2"}, ReadData2, e.rd2);
            check({tag, " WriteData"}, WriteData, e.wd);
            check({tag, " WriteCount"}, WriteCount, e.cnt);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic we, input logic [1:0] sel,
                                input logic [4:0] dst, input logic [31:0] alu,
                                input logic [31:0] mem, input logic [31:0] link,
                                input logic [4:0] rr1, input logic [4:0] rr2,
                                input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [31:0] wd, input logic [31:0] cnt);
        vec_t v;
        v.rst = rst; v.we = we; v.sel = sel; v.dst = dst;
        v.alu = alu; v.mem = mem; v.link = link; v.rr1 = rr1; v.rr2 = rr2;
        v.exp_rd1 = rd1; v.exp_rd2 = rd2; v.exp_wd = wd; v.exp_cnt = cnt;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        // exp_cnt is WriteCount during the cycle, i.e. after all earlier edges.
        //          rst we  sel  dst  alu            mem            link           rr1 rr2  rd1            rd2            wd             cnt
        vecs[0]  = mk(0, 1, 2'd0, 5,  32'h0000_00AB, 32'h111,       32'h222,       5,  0,  32'h0000_00AB, 32'h0,         32'h0000_00AB, 0);
        vecs[1]  = mk(0, 0, 2'd0, 5,  32'h333,       32'h0,         32'h0,         5,  5,  32'h0000_00AB, 32'h0000_00AB, 32'h333,       1);
        vecs[2]  = mk(0, 1, 2'd2, 31, 32'h444,       32'h0,         32'h0040_0008, 31, 5,  32'h0040_0008, 32'h0000_00AB, 32'h0040_0008, 1);
        vecs[3]  = mk(0, 0, 2'd1, 31, 32'h0,         32'h555,       32'h0,         31, 31, 32'h0040_0008, 32'h0040_0008, 32'h555,       2);
        vecs[4]  = mk(0, 1, 2'd1, 31, 32'h0,         32'hDEAD_BEEF, 32'h0,         31, 31, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2);
        vecs[5]  = mk(0, 0, 2'd3, 31, 32'h77,        32'h88,        32'h99,        31, 0,  32'hDEAD_BEEF, 32'h0,         32'h77,        3);
        vecs[6]  = mk(0, 1, 2'd0, 0,  32'hFFFF_FFFF, 32'h0,         32'h0,         0,  0,  32'h0,         32'h0,         32'hFFFF_FFFF, 3);
        vecs[7]  = mk(0, 0, 2'd0, 0,  32'h0,         32'h0,         32'h0,         0,  5,  32'h0,         32'h0000_00AB, 32'h0,         3);
        vecs[8]  = mk(0, 1, 2'd3, 9,  32'h0A0A,      32'h1,         32'h2,         9,  9,  32'h0A0A,      32'h0A0A,      32'h0A0A,      3);
        vecs[9]  = mk(0, 1, 2'd0, 9,  32'h0B0B,      32'h0,         32'h0,         9,  5,  32'h0B0B,      32'h0000_00AB, 32'h0B0B,      4);
        vecs[10] = mk(0, 0, 2'd0, 9,  32'hC,         32'h0,         32'h0,         9,  8,  32'h0B0B,      32'h0,         32'hC,         5);
        vecs[11] = mk(1, 1, 2'd0, 7,  32'h1234,      32'h0,         32'h0,         7,  31, 32'h0,         32'h0,         32'h1234,      5);
        vecs[12] = mk(0, 0, 2'd0, 7,  32'h0,         32'h0,         32'h0,         7,  31, 32'h0,         32'h0,         32'h0,         0);
        vecs[13] = mk(0, 1, 2'd0, 7,  32'h1234,      32'h0,         32'h0,         7,  31, 32'h1234,      32'h0,         32'h1234,      0);
        vecs[14] = mk(0, 0, 2'd0, 7,  32'h0,         32'h0,         32'h0,         7,  9,  32'h1234,      32'h0,         32'h0,         1);

        Reset = 1'b1; RegWrite3 = 1'b0; MemtoReg3 = 2'd0; MEMWBRTorRd = '0;
        ALUResult_out2 = '0; ReadData_out = '0; PCAddResult4 = '0;
        ReadRegister1 = '0; ReadRegister2 = '0;
        repeat (3) @(posedge Clk);

        // After reset every index reads 0 on both ports and the counter is 0.
        for (int i = 0; i < 32; i++) begin
            v = mk(0, 0, 2'd0, 0, 32'h0, 32'h0, 32'h0, 5'(i), 5'(31 - i),
                   32'h0, 32'h0, 32'h0, 32'h0);
            drive(v);
            sample($sformatf("reset_read idx%0d", i));
        end

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i]);
            sample($sformatf("vec%0d", i));
        end

        // Counter wrap: preload all-ones, commit one write, expect zero afterwards.
        @(posedge Clk);
        #1;
        dut.write_count_q = 32'hFFFF_FFFF;
        Reset = 1'b0; RegWrite3 = 1'b1; MemtoReg3 = 2'd0; MEMWBRTorRd = 5'd3;
        ALUResult_out2 = 32'h5A; ReadRegister1 = 5'd3; ReadRegister2 = 5'd0;
        @(negedge Clk);
        check("wrap pre WriteCount", WriteCount, 32'hFFFF_FFFF);
        @(posedge Clk);
        #1;
        RegWrite3 = 1'b0; ALUResult_out2 = 32'h0;
        @(negedge Clk);
        check("wrap post WriteCount", WriteCount, 32'h0);
        check("wrap post R3", ReadData1, 32'h5A);

        // Hold: with RegWrite3 low a changing WriteData must not disturb state.
        @(posedge Clk);
        #1;
        ALUResult_out2 = 32'hFFFF_0000; MEMWBRTorRd = 5'd3;
        @(posedge Clk);
        #1;
        @(negedge Clk);
        check("hold R3", ReadData1, 32'h5A);
        check("hold WriteCount", WriteCount, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
